fifo1_frame_reader: RTL and testbench
=====================================

# fifo1_frame_reader

Read-side consumer of the 31-bit prefetch FIFO in the audio FFT/FIR path. It pops samples from the FIFO, which presents data with a valid flag. It slices the sample stream into fixed-length frames and delivers them to the FFT input over a valid/ready stream with start-of-frame and end-of-frame markers. Frame runs are started and aborted by the control logic. An aborted run always ends on a frame boundary, so the FFT never sees a partial frame.

## Interface
Parameters:
- `DATA_WIDTH`, 31: sample width; must match the FIFO read width.
- `FRAME_LEN_LOG2`, 10: frame length = 2^FRAME_LEN_LOG2 samples; legal range 2..16.
- `CNT_WIDTH`, 16: width of the frame-count request and status counters.

Ports:
- `rd_clk`  in  1  clock; the FIFO read clock.
- `rd_rst`  in  1  reset; synchronous, active-high.
- `start`  in  1  single-cycle pulse that begins a run; honoured only when `busy`=0.
- `abort`  in  1  single-cycle pulse that ends the run at the next frame boundary.
- `frame_num`  in  CNT_WIDTH  number of frames per run; latched on `start`; 0 = continuous.
- `fifo_rd_en`  out  1  pop strobe to the FIFO.
- `fifo_rd_vld`  in  1  FIFO has a word on `fifo_rd_data`.
- `fifo_rd_data`  in  DATA_WIDTH  FIFO head word.
- `m_data`  out  DATA_WIDTH  frame sample.
- `m_vld`  out  1  `m_data`, `m_sop` and `m_eop` are valid.
- `m_rdy`  in  1  FFT accepts the beat.
- `m_sop`  out  1  first sample of a frame.
- `m_eop`  out  1  last sample of a frame.
- `busy`  out  1  equals (state != IDLE) or `m_vld`.
- `frame_cnt`  out  CNT_WIDTH  frames completed in the current or last run; saturates at its maximum value.

## Operation
- State machine: IDLE, STREAM, PAD. PAD exists only when `FRAME_PAD_EN` is defined.
- Output register:
  - A single register stage holds `m_data`, `m_sop` and `m_eop`.
  - `load = (state==STREAM && fifo_rd_vld || state==PAD) && (!m_vld || m_rdy)`.
  - `fifo_rd_en = load && state==STREAM`. Words are popped only when they will be loaded.
  - On `load`, `m_vld` is set to 1. On a handshake without `load`, `m_vld` is cleared to 0.
- Sample counter `smp_cnt`:
  - FRAME_LEN_LOG2 bits wide; increments on every `load` and wraps from 2^FRAME_LEN_LOG2−1 to 0.
  - A loaded beat gets `m_sop` = (smp_cnt==0) and `m_eop` = (smp_cnt==all-ones).
- IDLE:
  - `start` with `busy`=0 latches `frame_num`, clears `frame_cnt`, `smp_cnt` and `abort_pend`, then moves to STREAM.
  - `abort` has no effect in IDLE.
- STREAM: loads FIFO words. When an eop beat is loaded, the state moves to IDLE if any of the following holds:
  - `frame_num`≠0 and `frame_cnt` + 1 (counting frames already loaded) equals `frame_num`;
  - `abort_pend` is set;
  - `abort` is asserted in that same cycle.
- Abort handling:
  - `abort` in STREAM while `smp_cnt`==0 and no `load` in that cycle: move to IDLE at once, with no partial frame.
  - `abort` in STREAM with `smp_cnt`≠0: behaviour is defined under Configuration.
- `frame_cnt`:
  - Increments on each eop handshake (`m_vld && m_rdy && m_eop`).
  - Because the run ends only after the final eop is loaded, `busy` stays high until that beat is accepted.
- Reset (`rd_rst`=1 at a clock edge):
  - state=IDLE, `m_vld`=0, `m_data`=0, `m_sop`=0, `m_eop`=0, `fifo_rd_en`=0, `busy`=0, `frame_cnt`=0, `smp_cnt`=0, `abort_pend`=0.
  - Reset mid-frame discards the beat held in the output register. No FIFO pop occurs in the reset cycle.

## Timing
- Latency from FIFO pop to `m_vld`: 1 cycle. With `m_rdy` held at 1 and the FIFO never empty, throughput is 1 sample per cycle.
- While `m_vld`=1 and `m_rdy`=0, `m_data`, `m_sop` and `m_eop` stay stable and no pop occurs.
- FIFO empty mid-frame (`fifo_rd_vld`=0): bubbles are inserted and the frame continues when data returns. There is no timeout.
- `start` arriving while `busy`=1 is ignored and is not queued.
- `fifo_rd_en` is combinational from `fifo_rd_vld`, `m_vld` and `m_rdy`. There is no combinational path from `start` or `abort` to the outputs.

## Configuration
- Macro `FRAME_PAD_EN`.
- Defined: `abort` with `smp_cnt`≠0 moves to PAD.
  - PAD loads zero samples, with no FIFO pops, until the eop beat is loaded, then moves to IDLE.
  - Padded beats follow the normal `m_rdy` handshake.
- Not defined: `abort` with `smp_cnt`≠0 sets `abort_pend`.
  - STREAM continues popping real samples until the eop beat is loaded, then moves to IDLE.
  - The PAD state and its logic are not compiled.

## Test plan
- Continuous stream, FRAME_LEN_LOG2=3, `frame_num`=2, FIFO preloaded with 0..15, `m_rdy`=1:
  - Required: exactly 16 beats with data 0..15; `m_sop` on 0 and 8; `m_eop` on 7 and 15.
  - After beat 15, `busy` falls; `frame_cnt`=2; FIFO left empty.
- Backpressure: toggle `m_rdy` 1,0,0,1 repeatedly.
  - Required: data held stable while `m_rdy`=0; no `fifo_rd_en` while `m_vld`=1 and `m_rdy`=0; no sample lost or duplicated.
- FIFO underrun: drop `fifo_rd_vld` for 5 cycles after sample 3.
  - Required: `m_vld` low for 5 cycles; sample 4 follows sample 3 with `m_sop`/`m_eop` positions unchanged.
- Abort at `smp_cnt`=3, continuous run (`frame_num`=0):
  - With `FRAME_PAD_EN`: beats 0..2 of real data, then 5 zero beats, the last with `m_eop`=1; FIFO pops stop after 3 words.
  - Without `FRAME_PAD_EN`: 8 real beats ending with `m_eop`=1, then IDLE.
- `abort` pulse on the same cycle as the eop load: the run ends after that frame, no extra frame follows, and `frame_cnt`=1.
- `rd_rst` held for one cycle mid-frame with `m_vld`=1 and `m_rdy`=0:
  - Required: next cycle `m_vld`=0, `busy`=0, `frame_cnt`=0.
  - A following `start` begins a new frame with `m_sop` on its first beat.

Source files
------------

// File: rtl/fifo1_frame_reader_if.sv
// Sample stream from the frame reader to the FFT input: data plus
// start/end-of-frame markers under a valid/ready handshake.
interface fifo1_frame_reader_if #(
  parameter int DATA_WIDTH = 31
) ();
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_vld;
  logic                  m_rdy;
  logic                  m_sop;
  logic                  m_eop;

  modport master (
    output m_data,
    output m_vld,
    output m_sop,
    output m_eop,
    input  m_rdy
  );

  modport slave (
    input  m_data,
    input  m_vld,
    input  m_sop,
    input  m_eop,
    output m_rdy
  );
endinterface

// File: rtl/fifo1_frame_reader.sv
// Pops the prefetch FIFO and slices the samples into fixed-length frames for the FFT.
// Define FRAME_PAD_EN to zero-pad an aborted frame instead of finishing it with real samples.
module fifo1_frame_reader #(
  parameter int DATA_WIDTH     = 31,
  parameter int FRAME_LEN_LOG2 = 10,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [CNT_WIDTH-1:0]  frame_num,
  output logic                  fifo_rd_en,
  input  logic                  fifo_rd_vld,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  fifo1_frame_reader_if.master  m_if,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  frame_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1
`ifdef FRAME_PAD_EN
    ,
    PAD    = 2'd2
`endif
  } state_t;

  state_t                  state_reg, state_next;
  logic                    abort_pend_reg, abort_pend_next;
  logic [DATA_WIDTH-1:0]   m_data_reg;
  logic                    m_vld_reg;
  logic                    m_sop_reg;
  logic                    m_eop_reg;
  logic [FRAME_LEN_LOG2-1:0] smp_cnt_reg;
  logic [CNT_WIDTH-1:0]    frame_cnt_reg;
  logic [CNT_WIDTH-1:0]    frame_num_reg;

  logic in_stream;
  logic in_pad;
  logic load;
  logic smp_last;
  logic load_eop;
  logic accept;
  logic start_ok;
  logic run_done;

  assign in_stream = (state_reg == STREAM);
`ifdef FRAME_PAD_EN
  assign in_pad = (state_reg == PAD);
`else
  assign in_pad = 1'b0;
`endif

  // The output register refills whenever it is empty or being drained this cycle.
  assign load       = ((in_stream && fifo_rd_vld) || in_pad) && (!m_vld_reg || m_if.m_rdy);
  assign fifo_rd_en = load && in_stream && !rd_rst;
  assign smp_last   = &smp_cnt_reg;
  assign load_eop   = load && smp_last;
  assign accept     = m_vld_reg && m_if.m_rdy;
  assign busy       = (state_reg != IDLE) || m_vld_reg;
  assign start_ok   = start && !busy;

  // The eop handshake of the previous frame always precedes the next eop load,
  // so frame_cnt already counts every earlier frame here.
  assign run_done = (frame_num_reg != '0) &&
                    (({1'b0, frame_cnt_reg} + 1'b1) == {1'b0, frame_num_reg});

  always_comb begin
    state_next      = state_reg;
    abort_pend_next = abort_pend_reg;
    case (state_reg)
      IDLE: begin
        if (start_ok) begin
          state_next      = STREAM;
          abort_pend_next = 1'b0;
        end
      end
      STREAM: begin
        if (load_eop && (run_done || abort_pend_reg || abort)) begin
          state_next = IDLE;
        end else if (abort && (smp_cnt_reg == '0) && !load) begin
          state_next = IDLE;
        end else if (abort) begin
`ifdef FRAME_PAD_EN
          state_next = PAD;
`else
          abort_pend_next = 1'b1;
`endif
        end
      end
`ifdef FRAME_PAD_EN
      PAD: begin
        if (load_eop) begin
          state_next = IDLE;
        end
      end
`endif
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      state_reg      <= IDLE;
      abort_pend_reg <= 1'b0;
      m_data_reg     <= '0;
      m_vld_reg      <= 1'b0;
      m_sop_reg      <= 1'b0;
      m_eop_reg      <= 1'b0;
      smp_cnt_reg    <= '0;
      frame_cnt_reg  <= '0;
      frame_num_reg  <= '0;
    end else begin
      state_reg      <= state_next;
      abort_pend_reg <= abort_pend_next;

      if (start_ok) begin
        frame_num_reg <= frame_num;
      end

      if (start_ok) begin
        smp_cnt_reg <= '0;
      end else if (load) begin
        smp_cnt_reg <= smp_cnt_reg + 1'b1;
      end

      if (start_ok) begin
        frame_cnt_reg <= '0;
      end else if (accept && m_eop_reg && (frame_cnt_reg != '1)) begin
        frame_cnt_reg <= frame_cnt_reg + 1'b1;
      end

      if (load) begin
        m_vld_reg <= 1'b1;
      end else if (accept) begin
        m_vld_reg <= 1'b0;
      end

      if (load) begin
        m_data_reg <= in_stream ? fifo_rd_data : '0;
        m_sop_reg  <= (smp_cnt_reg == '0);
        m_eop_reg  <= smp_last;
      end
    end
  end

  assign m_if.m_data = m_data_reg;
  assign m_if.m_vld  = m_vld_reg;
  assign m_if.m_sop  = m_sop_reg;
  assign m_if.m_eop  = m_eop_reg;
  assign frame_cnt   = frame_cnt_reg;

endmodule

// File: tb/tb_fifo1_frame_reader.sv
// Scoreboard bench for fifo1_frame_reader with 8-sample frames: a FIFO model feeds the
// reader and the expected beat stream is derived from the words pushed into it.
module tb_fifo1_frame_reader;
  localparam int DW   = 31;
  localparam int FL   = 3;
  localparam int CW   = 16;
  localparam int FLEN = 8;

  logic          rd_clk = 1'b0;
  logic          rd_rst;
  logic          start;
  logic          abort;
  logic [CW-1:0] frame_num;
  logic          fifo_rd_en;
  logic          fifo_rd_vld;
  logic [DW-1:0] fifo_rd_data;
  logic          busy;
  logic [CW-1:0] frame_cnt;
  logic          m_rdy;

  fifo1_frame_reader_if #(.DATA_WIDTH(DW)) m_if ();
  assign m_if.m_rdy = m_rdy;

  fifo1_frame_reader #(
    .DATA_WIDTH(DW),
    .FRAME_LEN_LOG2(FL),
    .CNT_WIDTH(CW)
  ) dut (
    .rd_clk(rd_clk),
    .rd_rst(rd_rst),
    .start(start),
    .abort(abort),
    .frame_num(frame_num),
    .fifo_rd_en(fifo_rd_en),
    .fifo_rd_vld(fifo_rd_vld),
    .fifo_rd_data(fifo_rd_data),
    .m_if(m_if),
    .busy(busy),
    .frame_cnt(frame_cnt)
  );

  always #5 rd_clk = ~rd_clk;

  // FIFO model
  logic [DW-1:0] mem [0:1023];
  int            wr_ptr;
  int            rd_ptr;
  int            pops;
  logic          vld_en;
  logic          flush_req;

  assign fifo_rd_vld  = vld_en && (wr_ptr != rd_ptr);
  assign fifo_rd_data = mem[rd_ptr[9:0]];

  always @(posedge rd_clk) begin
    if (flush_req) begin
      rd_ptr <= wr_ptr;
    end else if (fifo_rd_en) begin
      rd_ptr <= rd_ptr + 1;
      pops   <= pops + 1;
    end
  end

  typedef struct packed {
    logic [DW-1:0] d;
    logic          sop;
    logic          eop;
  } beat_t;

  beat_t         exp_q[$];
  logic [DW-1:0] model_q[$];
  int            total = 0;
  int            bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic fifo_push(input logic [DW-1:0] v);
    mem[wr_ptr[9:0]] = v;
    wr_ptr = wr_ptr + 1;
    model_q.push_back(v);
  endtask

  function automatic int fifo_level();
    return wr_ptr - rd_ptr;
  endfunction

  // Expected beats: the next n FIFO words, starting at frame position pos0.
  task automatic exp_real(input int n, input int pos0);
    beat_t b;
    int    pos;
    for (int i = 0; i < n; i++) begin
      pos   = (pos0 + i) % FLEN;
      b.d   = model_q.pop_front();
      b.sop = (pos == 0);
      b.eop = (pos == FLEN - 1);
      exp_q.push_back(b);
    end
  endtask

  task automatic exp_zero(input int n, input int pos0);
    beat_t b;
    int    pos;
    for (int i = 0; i < n; i++) begin
      pos   = (pos0 + i) % FLEN;
      b.d   = '0;
      b.sop = (pos == 0);
      b.eop = (pos == FLEN - 1);
      exp_q.push_back(b);
    end
  endtask

  // Monitor: every accepted beat is checked against the scoreboard head.
  logic  stall_prev = 1'b0;
  beat_t held;
  always @(negedge rd_clk) begin
    beat_t cur;
    beat_t e;
    cur.d   = m_if.m_data;
    cur.sop = m_if.m_sop;
    cur.eop = m_if.m_eop;
    if (!rd_rst) begin
      if (stall_prev) begin
        chk("hold_vld", {63'd0, m_if.m_vld}, 64'd1);
        chk("hold_beat", {31'd0, cur}, {31'd0, held});
      end
      if (m_if.m_vld && !m_rdy) begin
        chk("no_pop_in_stall", {63'd0, fifo_rd_en}, 64'd0);
      end
      if (m_if.m_vld && m_rdy) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", {33'd0, cur.d}, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("beat_data", {33'd0, cur.d}, {33'd0, e.d});
          chk("beat_sop", {63'd0, cur.sop}, {63'd0, e.sop});
          chk("beat_eop", {63'd0, cur.eop}, {63'd0, e.eop});
        end
      end
      stall_prev <= m_if.m_vld && !m_rdy;
      held       <= cur;
    end else begin
      stall_prev <= 1'b0;
    end
  end

  task automatic tick();
    @(posedge rd_clk);
    #1;
  endtask

  task automatic pulse_start(input int nf);
    frame_num = CW'(nf);
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  task automatic flush();
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    model_q.delete();
    exp_q.delete();
  endtask

  // rdy_mode: 0 always ready, 1 pattern 1,0,0,1, 2 random.
  task automatic wait_idle(input int budget, input int rdy_mode, input int gap_pct,
                           input bit stray, input string name);
    int cyc = 0;
    while (busy && cyc < budget) begin
      case (rdy_mode)
        0:       m_rdy = 1'b1;
        1:       m_rdy = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        default: m_rdy = ($urandom_range(0, 99) < 60);
      endcase
      vld_en = ($urandom_range(0, 99) >= gap_pct);
      start  = stray && ($urandom_range(0, 9) == 0);
      tick();
      cyc++;
    end
    start  = 1'b0;
    m_rdy  = 1'b1;
    vld_en = 1'b1;
    chk(name, {63'd0, busy}, 64'd0);
  endtask

  task automatic wait_pops(input int target, input int p0, input string name);
    int cyc = 0;
    while ((pops - p0) < target && cyc < 200) begin
      tick();
      cyc++;
    end
    chk(name, 64'(pops - p0), 64'(target));
  endtask

  task automatic run(input int nf, input int extra, input int rdy_mode, input int gap_pct,
                     input bit stray, input bit seq, input int base);
    for (int i = 0; i < nf * FLEN + extra; i++) begin
      if (seq) fifo_push(DW'(base + i));
      else     fifo_push(DW'($urandom));
    end
    exp_real(nf * FLEN, 0);
    pulse_start(nf);
    wait_idle(2000, rdy_mode, gap_pct, stray, "run_timeout");
    chk("run_frame_cnt", 64'(frame_cnt), 64'(nf));
    chk("run_fifo_left", 64'(fifo_level()), 64'(extra));
    chk("run_sb_empty", 64'(exp_q.size()), 64'd0);
    flush();
  endtask

  int p0;
  int remain;

  initial begin
    rd_rst    = 1'b1;
    start     = 1'b0;
    abort     = 1'b0;
    frame_num = '0;
    m_rdy     = 1'b1;
    vld_en    = 1'b1;
    flush_req = 1'b0;
    repeat (3) @(posedge rd_clk);
    #1;
    rd_rst = 1'b0;

    chk("rst_m_vld", {63'd0, m_if.m_vld}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_frame_cnt", 64'(frame_cnt), 64'd0);
    chk("rst_m_data", {33'd0, m_if.m_data}, 64'd0);
    chk("rst_sop_eop", {62'd0, m_if.m_sop, m_if.m_eop}, 64'd0);
    chk("rst_rd_en", {63'd0, fifo_rd_en}, 64'd0);

    // Two frames of 0..15, full rate, FIFO left empty
    run(2, 0, 0, 0, 1'b0, 1'b1, 0);

    // Backpressure 1,0,0,1
    run(2, 1, 1, 0, 1'b0, 1'b1, 600);

    // Underrun of 5 cycles after sample 3
    for (int i = 0; i < 16; i++) fifo_push(DW'(500 + i));
    exp_real(16, 0);
    p0 = pops;
    pulse_start(2);
    wait_pops(4, p0, "underrun_reach");
    vld_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge rd_clk);
      @(negedge rd_clk);
      chk("underrun_bubble", {63'd0, m_if.m_vld}, 64'd0);
    end
    vld_en = 1'b1;
    wait_idle(200, 0, 0, 1'b0, "underrun_timeout");
    chk("underrun_frame_cnt", 64'(frame_cnt), 64'd2);
    chk("underrun_fifo_left", 64'(fifo_level()), 64'd0);
    chk("underrun_sb_empty", 64'(exp_q.size()), 64'd0);
    flush();

    // Abort at smp_cnt=3 in a continuous run
    for (int i = 0; i < 16; i++) fifo_push(DW'(100 + i));
`ifdef FRAME_PAD_EN
    exp_real(3, 0);
    exp_zero(5, 3);
    remain = 13;
`else
    exp_real(8, 0);
    remain = 8;
`endif
    p0 = pops;
    pulse_start(0);
    wait_pops(3, p0, "abort_reach");
    vld_en = 1'b0;
    abort  = 1'b1;
    tick();
    abort  = 1'b0;
    vld_en = 1'b1;
    wait_idle(200, 0, 0, 1'b0, "abort_timeout");
    chk("abort_frame_cnt", 64'(frame_cnt), 64'd1);
    chk("abort_fifo_left", 64'(fifo_level()), 64'(remain));
    chk("abort_sb_empty", 64'(exp_q.size()), 64'd0);
    flush();

    // Abort on the same cycle as the eop load
    for (int i = 0; i < 16; i++) fifo_push(DW'(200 + i));
    exp_real(8, 0);
    p0 = pops;
    pulse_start(0);
    wait_pops(7, p0, "eop_abort_reach");
    abort = 1'b1;
    tick();
    abort = 1'b0;
    wait_idle(200, 0, 0, 1'b0, "eop_abort_timeout");
    chk("eop_abort_frame_cnt", 64'(frame_cnt), 64'd1);
    chk("eop_abort_fifo_left", 64'(fifo_level()), 64'd8);
    chk("eop_abort_sb_empty", 64'(exp_q.size()), 64'd0);
    flush();

    // Reset mid-frame while stalled
    for (int i = 0; i < 16; i++) fifo_push(DW'(300 + i));
    exp_real(8, 0);
    p0 = pops;
    pulse_start(1);
    wait_pops(3, p0, "rst_reach");
    m_rdy = 1'b0;
    tick();
    chk("pre_rst_vld", {63'd0, m_if.m_vld}, 64'd1);
    rd_rst = 1'b1;
    @(negedge rd_clk);
    chk("rst_cycle_no_pop", {63'd0, fifo_rd_en}, 64'd0);
    @(posedge rd_clk);
    #1;
    rd_rst = 1'b0;
    m_rdy  = 1'b1;
    chk("midrst_m_vld", {63'd0, m_if.m_vld}, 64'd0);
    chk("midrst_busy", {63'd0, busy}, 64'd0);
    chk("midrst_frame_cnt", 64'(frame_cnt), 64'd0);
    flush();
    run(1, 0, 0, 0, 1'b0, 1'b1, 400);

    // Randomized runs: random backpressure, FIFO gaps and ignored start pulses
    for (int r = 0; r < 6; r++) begin
      run($urandom_range(1, 3), $urandom_range(0, 3), 2, 30, 1'b1, 1'b0, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
